meas_sequencer: RTL and testbench

Parametrised multi-channel measurement sequencer, successor to the single-mode controller FSM. For each enabled analog-mux channel, it runs the same sequence: load the range/key register over the shared DAC/register SPI master, enable the sine generator, select the mux channel, wait a programmable number of generator periods, trigger one ADC read cycle, and hand the two results downstream over a valid/ready port. It sits between the host control registers and the existing `spi_master`, `sin_gen` and `adc_read` instances.

---
 rtl/meas_sequencer.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_meas_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/meas_sequencer.sv
// meas_sequencer: multi-channel measurement sequencer.
// For every enabled mux channel it programs the range/key register over the
// shared SPI master, runs the sine generator, selects the channel, waits a
// programmable number of generator periods, triggers one ADC read cycle and
// hands both results downstream over a valid/ready port.
//
// Ports
//   clk, rst_n                  system clock, async active-low reset
//   start, abort                sweep request / sweep termination
//   chn_mask, mux_codes         channel enables and per-channel mux codes
//   range_code, keys            register byte contents
//   settle_periods              generator periods to wait per channel
//   reg_data/reg_start/reg_done SPI register-load handshake
//   cs_dac_reg                  chip select (3 none, 2 register, 1 DAC)
//   gen_enable/gen_new_period   sine generator control / period tick
//   mux_chn                     analog mux select
//   adc_start/adc_complete      ADC read cycle handshake, adc_data_1/2 results
//   res_valid/res_ready         result handshake with res_chn, res_data_1/2
//   busy, done, aborted         sweep status
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for start
// ARM        | configuration latched, decide empty sweep vs. real sweep
// SET_REG    | reg_start pulse out, register selected
// WAIT_REG   | waiting for SPI completion
// GEN_ON     | generator running, DAC selected; pick first channel
// SEL_CHN    | mux switched with zero settle count, one cycle
// SETTLE     | counting generator periods down to the terminal count
// ADC_START  | adc_start pulse out
// ADC_WAIT   | waiting for adc_complete
// PUSH       | result offered downstream
// GEN_OFF    | generator off, chip select released, mux parked
// DONE       | done pulse out
module meas_sequencer #(
  parameter int NUM_CHN   = 4,
  parameter int MUX_WIDTH = 3,
  parameter int ADC_WIDTH = 24,
  parameter int SETTLE_W  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NUM_CHN-1:0]           chn_mask,
  input  logic [NUM_CHN*MUX_WIDTH-1:0] mux_codes,
  input  logic [2:0]                   range_code,
  input  logic [4:0]                   keys,
  input  logic [SETTLE_W-1:0]          settle_periods,
  output logic [7:0]                   reg_data,
  output logic                         reg_start,
  input  logic                         reg_done,
  output logic [1:0]                   cs_dac_reg,
  output logic                         gen_enable,
  input  logic                         gen_new_period,
  output logic [MUX_WIDTH-1:0]         mux_chn,
  output logic                         adc_start,
  input  logic                         adc_complete,
  input  logic [ADC_WIDTH-1:0]         adc_data_1,
  input  logic [ADC_WIDTH-1:0]         adc_data_2,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [2:0]                   res_chn,
  output logic [ADC_WIDTH-1:0]         res_data_1,
  output logic [ADC_WIDTH-1:0]         res_data_2,
  output logic                         busy,
  output logic                         done,
  output logic                         aborted
);

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_SET_REG, S_WAIT_REG, S_GEN_ON, S_SEL_CHN,
    S_SETTLE, S_ADC_START, S_ADC_WAIT, S_PUSH, S_GEN_OFF, S_DONE
  } state_t;

  state_t                       state_q, state_d;
  logic [NUM_CHN-1:0]           pend_q, pend_d;
  logic [NUM_CHN*MUX_WIDTH-1:0] codes_q;
  logic [2:0]                   range_q;
  logic [4:0]                   keys_q;
  logic [SETTLE_W-1:0]          settle_q;
  logic [SETTLE_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                   cur_chn_q, cur_chn_d;

  logic [7:0]           reg_data_d;
  logic                 reg_start_d, gen_en_d, adc_start_d, res_valid_d;
  logic                 busy_d, done_d, aborted_d;
  logic [1:0]           cs_d;
  logic [MUX_WIDTH-1:0] mux_d;
  logic                 latch_en, cap_en, do_pick, go_off;

  logic [2:0]         pick_idx;
  logic [NUM_CHN-1:0] pick_bit;

  // lowest-index channel still pending in this sweep
  always_comb begin
    pick_idx = '0;
    pick_bit = '0;
    for (int i = NUM_CHN - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        pick_idx    = 3'(i);
        pick_bit    = '0;
        pick_bit[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    cur_chn_d   = cur_chn_q;
    reg_data_d  = reg_data;
    reg_start_d = 1'b0;
    cs_d        = cs_dac_reg;
    gen_en_d    = gen_enable;
    mux_d       = mux_chn;
    adc_start_d = 1'b0;
    res_valid_d = res_valid;
    busy_d      = busy;
    done_d      = 1'b0;
    aborted_d   = aborted;
    latch_en    = 1'b0;
    cap_en      = 1'b0;
    do_pick     = 1'b0;
    go_off      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          latch_en  = 1'b1;
          aborted_d = 1'b0;
          state_d   = S_ARM;
        end
      end
      S_ARM: begin
        if (pend_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d     = S_SET_REG;
          busy_d      = 1'b1;
          cs_d        = 2'd2;
          reg_data_d  = {range_q, keys_q};
          reg_start_d = 1'b1;
        end
      end
      S_SET_REG: state_d = S_WAIT_REG;
      S_WAIT_REG: begin
        if (reg_done) begin
          state_d  = S_GEN_ON;
          cs_d     = 2'd1;
          gen_en_d = 1'b1;
        end
      end
      S_GEN_ON: do_pick = 1'b1;
      S_SEL_CHN: begin
        state_d     = S_ADC_START;
        adc_start_d = 1'b1;
      end
      S_SETTLE: begin
        if (gen_new_period) begin
          if (cnt_q == SETTLE_W'(1)) begin
            state_d     = S_ADC_START;
            adc_start_d = 1'b1;
          end else begin
            cnt_d = cnt_q - SETTLE_W'(1);
          end
        end
      end
      S_ADC_START: state_d = S_ADC_WAIT;
      S_ADC_WAIT: begin
        if (adc_complete) begin
          cap_en  = 1'b1;
          state_d = S_PUSH;
        end
      end
      // res_valid rises one cycle after capture, so the data registers are
      // already stable when it is first seen
      S_PUSH: begin
        if (res_valid && res_ready) begin
          res_valid_d = 1'b0;
          if (pend_q != '0) do_pick = 1'b1;
          else              go_off  = 1'b1;
        end else begin
          res_valid_d = 1'b1;
        end
      end
      S_GEN_OFF: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && !(state_q inside {S_IDLE, S_GEN_OFF, S_DONE})) begin
      go_off    = 1'b1;
      aborted_d = 1'b1;
      do_pick   = 1'b0;
      cap_en    = 1'b0;
    end

    // settle periods are counted from the first edge after the mux change
    if (do_pick) begin
      pend_d    = pend_q & ~pick_bit;
      cur_chn_d = pick_idx;
      mux_d     = codes_q[int'(pick_idx) * MUX_WIDTH +: MUX_WIDTH];
      cnt_d     = settle_q;
      state_d   = (settle_q == '0) ? S_SEL_CHN : S_SETTLE;
    end

    if (go_off) begin
      state_d     = S_GEN_OFF;
      gen_en_d    = 1'b0;
      cs_d        = 2'd3;
      mux_d       = '0;
      res_valid_d = 1'b0;
      reg_start_d = 1'b0;
      adc_start_d = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pend_q     <= '0;
      codes_q    <= '0;
      range_q    <= '0;
      keys_q     <= '0;
      settle_q   <= '0;
      cnt_q      <= '0;
      cur_chn_q  <= '0;
      reg_data   <= '0;
      reg_start  <= 1'b0;
      cs_dac_reg <= 2'd3;
      gen_enable <= 1'b0;
      mux_chn    <= '0;
      adc_start  <= 1'b0;
      res_valid  <= 1'b0;
      res_chn    <= '0;
      res_data_1 <= '0;
      res_data_2 <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_chn_q  <= cur_chn_d;
      reg_data   <= reg_data_d;
      reg_start  <= reg_start_d;
      cs_dac_reg <= cs_d;
      gen_enable <= gen_en_d;
      mux_chn    <= mux_d;
      adc_start  <= adc_start_d;
      res_valid  <= res_valid_d;
      busy       <= busy_d;
      done       <= done_d;
      aborted    <= aborted_d;
      if (latch_en) begin
        pend_q   <= chn_mask;
        codes_q  <= mux_codes;
        range_q  <= range_code;
        keys_q   <= keys;
        settle_q <= settle_periods;
      end else begin
        pend_q   <= pend_d;
      end
      if (cap_en) begin
        res_data_1 <= adc_data_1;
        res_data_2 <= adc_data_2;
        res_chn    <= cur_chn_q;
      end
    end
  end

endmodule

// File: tb/tb_meas_sequencer.sv
// tb_meas_sequencer: directed bench for meas_sequencer. A negedge-driven
// environment emulates the SPI master, sine generator, ADC reader and result
// sink, and logs every event; the main sequence launches sweeps and compares
// the logs against hand-derived expectations.
`timescale 1ns/1ps
module tb_meas_sequencer;
  localparam int NUM_CHN = 4, MUX_WIDTH = 3, ADC_WIDTH = 24, SETTLE_W = 4;

  logic                         clk = 1'b0, rst_n = 1'b0;
  logic                         start = 1'b0, abort = 1'b0;
  logic [NUM_CHN-1:0]           chn_mask = '0;
  logic [NUM_CHN*MUX_WIDTH-1:0] mux_codes = '0;
  logic [2:0]                   range_code = '0;
  logic [4:0]                   keys = '0;
  logic [SETTLE_W-1:0]          settle_periods = '0;
  logic [7:0]                   reg_data;
  logic                         reg_start, reg_done = 1'b0;
  logic [1:0]                   cs_dac_reg;
  logic                         gen_enable, gen_new_period = 1'b0;
  logic [MUX_WIDTH-1:0]         mux_chn;
  logic                         adc_start, adc_complete = 1'b0;
  logic [ADC_WIDTH-1:0]         adc_data_1 = '0, adc_data_2 = '0;
  logic                         res_valid, res_ready = 1'b1;
  logic [2:0]                   res_chn;
  logic [ADC_WIDTH-1:0]         res_data_1, res_data_2;
  logic                         busy, done, aborted;

  meas_sequencer #(.NUM_CHN(NUM_CHN), .MUX_WIDTH(MUX_WIDTH),
                   .ADC_WIDTH(ADC_WIDTH), .SETTLE_W(SETTLE_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .chn_mask(chn_mask), .mux_codes(mux_codes), .range_code(range_code),
    .keys(keys), .settle_periods(settle_periods),
    .reg_data(reg_data), .reg_start(reg_start), .reg_done(reg_done),
    .cs_dac_reg(cs_dac_reg), .gen_enable(gen_enable),
    .gen_new_period(gen_new_period), .mux_chn(mux_chn),
    .adc_start(adc_start), .adc_complete(adc_complete),
    .adc_data_1(adc_data_1), .adc_data_2(adc_data_2),
    .res_valid(res_valid), .res_ready(res_ready), .res_chn(res_chn),
    .res_data_1(res_data_1), .res_data_2(res_data_2),
    .busy(busy), .done(done), .aborted(aborted));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [23:0] exp_d1(input logic [2:0] code);
    return 24'hD10000 | 24'(code);
  endfunction

  function automatic logic [23:0] exp_d2(input logic [2:0] code);
    return 24'hE20000 | 24'(code);
  endfunction

  // environment state, written by main: env_settle, bp_cycles, exp_reg
  int   env_settle = 0, bp_cycles = 0;
  logic [7:0] exp_reg = '0;
  int   rd_cd = 0, adc_cd = 0, gen_ph = 0, bp_cnt = 0, pulses = 0, exp_adc = -1, vcount = 0;
  bit   armed = 0;
  logic [MUX_WIDTH-1:0] prev_mux = '0;
  logic prev_valid = 1'b0, prev_gen_en = 1'b0;
  logic [23:0] held_d1 = '0;
  logic [2:0]  held_chn = '0;
  int   n_reg_start = 0, n_adc = 0, n_done = 0, n_gen_rise = 0;
  int   rq_chn[$], rq_vlen[$];
  logic [23:0] rq_d1[$], rq_d2[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      rd_cd = 0; adc_cd = 0; armed = 0; exp_adc = -1; bp_cnt = 0; vcount = 0;
      reg_done = 1'b0; adc_complete = 1'b0; res_ready = 1'b1; gen_new_period = 1'b0;
      prev_mux = '0; prev_valid = 1'b0; prev_gen_en = 1'b0;
    end else begin
      if (reg_start) begin
        n_reg_start++;
        check_eq("reg_data", reg_data, exp_reg);
        check_eq("reg_cs", cs_dac_reg, 2);
        rd_cd = 3;
      end
      if (gen_enable && !prev_gen_en) n_gen_rise++;
      prev_gen_en = gen_enable;
      if (mux_chn != prev_mux) begin
        if (mux_chn != '0) begin
          if (env_settle == 0) begin exp_adc = cyc + 1; armed = 0; end
          else begin armed = 1; pulses = 0; end
        end else armed = 0;
      end
      prev_mux = mux_chn;
      if (adc_start) begin
        n_adc++;
        check_eq("adc_start_edge", cyc, exp_adc);
        exp_adc = -1;
        adc_cd = 3;
      end
      if (done) begin
        n_done++;
        check_eq("done_busy", busy, 0);
        check_eq("done_gen_cs", {gen_enable, cs_dac_reg}, 3'b011);
      end
      if (res_valid && prev_valid) begin
        vcount++;
        check_eq("res_hold_d1", res_data_1, held_d1);
        check_eq("res_hold_chn", res_chn, held_chn);
      end else if (res_valid) begin
        held_d1 = res_data_1; held_chn = res_chn; bp_cnt = bp_cycles; vcount = 1;
      end
      prev_valid = res_valid;
      if (res_valid && bp_cnt > 0) begin res_ready = 1'b0; bp_cnt--; end
      else res_ready = 1'b1;
      if (res_valid && res_ready) begin
        rq_chn.push_back(int'(res_chn)); rq_d1.push_back(res_data_1);
        rq_d2.push_back(res_data_2); rq_vlen.push_back(vcount);
      end
      if (rd_cd > 0) begin rd_cd--; reg_done = (rd_cd == 0); end
      else reg_done = 1'b0;
      if (adc_cd > 0) begin
        adc_cd--;
        adc_complete = (adc_cd == 0);
        if (adc_cd == 0) begin
          adc_data_1 = exp_d1(mux_chn);
          adc_data_2 = exp_d2(mux_chn);
        end
      end else adc_complete = 1'b0;
      gen_ph = (gen_ph + 1) % 4;
      gen_new_period = (gen_ph == 0);
      if (gen_new_period && armed) begin
        pulses++;
        if (pulses == env_settle) begin exp_adc = cyc + 1; armed = 0; end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // drives a one-cycle start, scrambles the inputs afterwards and checks
  // the first-cycle response
  task automatic launch(input logic [3:0] mask, input logic [11:0] codes,
                        input logic [2:0] rng, input logic [4:0] k, input int settle);
    chn_mask = mask; mux_codes = codes; range_code = rng; keys = k;
    settle_periods = SETTLE_W'(settle);
    env_settle = settle; exp_reg = {rng, k};
    start = 1'b1;
    tick();
    start = 1'b0;
    chn_mask = ~mask; mux_codes = ~codes; range_code = 3'b100; keys = ~k;
    settle_periods = SETTLE_W'(settle + 3);
    check_eq("busy_early", busy, 0);
    tick();
    if (mask != 0) begin
      check_eq("start_reg_start", reg_start, 1);
      check_eq("start_busy", busy, 1);
      check_eq("start_aborted_clr", aborted, 0);
    end else begin
      check_eq("empty_done", done, 1);
      check_eq("empty_busy", busy, 0);
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && n_done < target; i++) tick();
    check_eq("done_seen", n_done, target);
  endtask

  task automatic check_res(input int idx, input int chn, input logic [2:0] code);
    check_eq("res_chn", rq_chn[idx], chn);
    check_eq("res_d1", rq_d1[idx], exp_d1(code));
    check_eq("res_d2", rq_d2[idx], exp_d2(code));
  endtask

  // channel codes: ch0=5, ch1=6, ch2=3, ch3=7
  localparam logic [11:0] CODES = {3'd7, 3'd3, 3'd6, 3'd5};

  int d0, r0, a0, g0, q0;

  initial begin
    tick(2);
    check_eq("rst_outs",
             {reg_data, reg_start, cs_dac_reg, gen_enable, mux_chn, adc_start,
              res_valid, res_chn, busy, done, aborted},
             {8'h00, 1'b0, 2'b11, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0});
    check_eq("rst_data", res_data_1 | res_data_2, 0);
    rst_n = 1'b1;
    tick(2);

    // basic two-channel sweep, settle 2, sink always ready
    d0 = n_done; r0 = n_reg_start; a0 = n_adc; q0 = rq_chn.size();
    launch(4'b0101, CODES, 3'b010, 5'b10110, 2);
    wait_done(d0 + 1, 400);
    tick(5);
    check_eq("s1_reg_starts", n_reg_start - r0, 1);
    check_eq("s1_adc_starts", n_adc - a0, 2);
    check_eq("s1_results", rq_chn.size() - q0, 2);
    check_res(q0, 0, 3'd5);
    check_res(q0 + 1, 2, 3'd3);
    check_eq("s1_vlen0", rq_vlen[q0], 1);
    check_eq("s1_vlen1", rq_vlen[q0 + 1], 1);
    check_eq("s1_done_once", n_done - d0, 1);
    check_eq("s1_gen_off", gen_enable, 0);

    // empty mask
    d0 = n_done; r0 = n_reg_start; a0 = n_adc; g0 = n_gen_rise;
    launch(4'b0000, CODES, 3'b001, 5'b00001, 1);
    tick(6);
    check_eq("s2_done_once", n_done - d0, 1);
    check_eq("s2_no_reg_start", n_reg_start - r0, 0);
    check_eq("s2_no_adc_start", n_adc - a0, 0);
    check_eq("s2_no_gen", n_gen_rise - g0, 0);

    // backpressure: sink holds ready low for 10 cycles per result
    bp_cycles = 10;
    d0 = n_done; a0 = n_adc; q0 = rq_chn.size();
    launch(4'b0011, CODES, 3'b100, 5'b01010, 1);
    wait_done(d0 + 1, 600);
    bp_cycles = 0;
    tick(3);
    check_eq("s3_results", rq_chn.size() - q0, 2);
    check_res(q0, 0, 3'd5);
    check_res(q0 + 1, 1, 3'd6);
    check_eq("s3_vlen", rq_vlen[q0], 11);
    check_eq("s3_adc_starts", n_adc - a0, 2);

    // abort during SETTLE of channel 1
    d0 = n_done; a0 = n_adc; q0 = rq_chn.size();
    launch(4'b1111, CODES, 3'b001, 5'b11111, 3);
    for (int i = 0; i < 400 && rq_chn.size() == q0; i++) tick();
    for (int i = 0; i < 100 && mux_chn != 3'd6; i++) tick();
    check_eq("s4_mux_ch1", mux_chn, 6);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("s4_abort_outs", {gen_enable, cs_dac_reg, mux_chn, res_valid, aborted},
             {1'b0, 2'b11, 3'd0, 1'b0, 1'b1});
    wait_done(d0 + 1, 10);
    tick(3);
    check_eq("s4_results", rq_chn.size() - q0, 1);
    check_res(q0, 0, 3'd5);
    check_eq("s4_adc_starts", n_adc - a0, 1);
    check_eq("s4_aborted_level", aborted, 1);

    // start together with abort in IDLE: not started, aborted kept
    d0 = n_done; r0 = n_reg_start;
    chn_mask = 4'b0001;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick(4);
    check_eq("s4b_busy", busy, 0);
    check_eq("s4b_no_reg", n_reg_start - r0, 0);
    check_eq("s4b_no_done", n_done - d0, 0);
    check_eq("s4b_aborted", aborted, 1);

    // settle 0 plus a second start while busy
    d0 = n_done; r0 = n_reg_start; a0 = n_adc; q0 = rq_chn.size();
    launch(4'b0110, CODES, 3'b010, 5'b00111, 0);
    tick(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d0 + 1, 400);
    tick(10);
    check_eq("s5_done_once", n_done - d0, 1);
    check_eq("s5_reg_starts", n_reg_start - r0, 1);
    check_eq("s5_adc_starts", n_adc - a0, 2);
    check_eq("s5_results", rq_chn.size() - q0, 2);
    check_res(q0, 1, 3'd6);
    check_res(q0 + 1, 2, 3'd3);

    // reset during ADC_WAIT, then a normal sweep
    a0 = n_adc;
    launch(4'b0001, CODES, 3'b100, 5'b10001, 1);
    for (int i = 0; i < 400 && n_adc == a0; i++) tick();
    check_eq("s6_adc_seen", n_adc - a0, 1);
    tick();
    d0 = n_done;
    rst_n = 1'b0;
    #1;
    check_eq("s6_rst_outs",
             {reg_data, reg_start, cs_dac_reg, gen_enable, mux_chn, adc_start,
              res_valid, res_chn, busy, done, aborted},
             {8'h00, 1'b0, 2'b11, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0});
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check_eq("s6_no_done", n_done - d0, 0);
    q0 = rq_chn.size();
    launch(4'b1000, CODES, 3'b001, 5'b01100, 1);
    wait_done(d0 + 1, 400);
    tick(3);
    check_eq("s6_results", rq_chn.size() - q0, 1);
    check_res(q0, 3, 3'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
